// File: rtl/axis_spi_slave_if.sv
// AXI-Stream style word channel shared by the TX and RX sides of the SPI slave.
interface axis_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    // Transfer happens on a clock edge where tvalid and tready are both high;
    // the source holds tdata/tvalid stable until that edge, and tvalid never
    // waits on tready.
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_spi_slave.sv
// SPI slave with AXI-Stream TX/RX word ports. SCLK, CS and MOSI are
// oversampled in the clk_i domain; SCLK edges are found from a history stage
// after the synchronizers, so clk_i must run at least 4x SCLK.
module axis_spi_slave #(
    parameter int SPI_MODE   = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic   clk_i,
    input  logic   arstn_i,
    input  logic   spi_clk_i,
    input  logic   spi_cs_i,
    input  logic   spi_mosi_i,
    output logic   spi_miso_o,
    output logic   spi_miso_oe_o,
    axis_if.slave  s_axis,
    axis_if.master m_axis,
    output logic   tx_underrun_o,
    output logic   rx_overrun_o
);

    localparam logic CPOL  = ((SPI_MODE >> 1) & 1) != 0;
    localparam logic CPHA  = (SPI_MODE & 1) != 0;
    localparam int   CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronizers and edge-detect history
    logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_h_q, sclk_h_d;
    logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

    // After reset the synchronizers hold idle values, not real pin samples.
    // The slave only arms once it has seen real CS high, so a CS that stayed
    // low across reset is not mistaken for a fresh falling edge.
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       cs_act_h_q, cs_act_h_d;

    // Datapath
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  rx_done_q, rx_done_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;
    logic                  oe_q, oe_d;

    // Decoded events for the current cycle
    logic cs_active, cs_fall;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, tx_load;

    // Next-state logic for synchronizers, TX/RX shifters and the stream ports
    always_comb begin
        sclk_s1_d    = spi_clk_i;
        sclk_s2_d    = sclk_s1_q;
        sclk_h_d     = sclk_s2_q;
        cs_s1_d      = spi_cs_i;
        cs_s2_d      = cs_s1_q;
        mosi_s1_d    = spi_mosi_i;
        mosi_s2_d    = mosi_s1_q;
        fill_d       = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        armed_d      = armed_q | ((fill_q == 2'd3) & cs_s2_q);
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        bit_cnt_d    = bit_cnt_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        rx_done_d    = 1'b0;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;

        cs_active  = armed_q & ~cs_s2_q;
        cs_act_h_d = cs_active;
        cs_fall    = cs_active & ~cs_act_h_q;
        oe_d       = cs_active;

        sclk_rise   = sclk_s2_q & ~sclk_h_q;
        sclk_fall   = ~sclk_s2_q & sclk_h_q;
        lead_edge   = CPOL ? sclk_fall : sclk_rise;
        trail_edge  = CPOL ? sclk_rise : sclk_fall;
        sample_edge = cs_active & (CPHA ? trail_edge : lead_edge);
        shift_edge  = cs_active & (CPHA ? lead_edge : trail_edge);

        // A word starts on CS fall (CPHA=0) or on a shift edge with the bit
        // counter at zero: the first leading edge for CPHA=1, the trailing
        // edge right after a completed word for CPHA=0.
        tx_load = (~CPHA & cs_fall) | (shift_edge & (bit_cnt_q == '0));

        if (tx_load) begin
            hold_valid_d = 1'b0;
        end
        if (s_axis.tvalid & ~hold_valid_q) begin
            hold_data_d  = s_axis.tdata;
            hold_valid_d = 1'b1;
        end

        if (!cs_active) begin
            tx_sr_d   = '0;
            rx_sr_d   = '0;
            bit_cnt_d = '0;
        end else begin
            if (tx_load) begin
                tx_sr_d    = hold_valid_q ? hold_data_q : '0;
                underrun_d = ~hold_valid_q;
            end else if (shift_edge) begin
                tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
                rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s2_q};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    rx_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        // rx_sr_q holds the full word in the cycle rx_done_q is high
        if (m_tvalid_q & m_axis.tready) begin
            m_tvalid_d = 1'b0;
        end
        if (rx_done_q) begin
            if (m_tvalid_q & ~m_axis.tready) begin
                overrun_d = 1'b1;
            end else begin
                m_tdata_d  = rx_sr_q;
                m_tvalid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            sclk_s1_q    <= CPOL;
            sclk_s2_q    <= CPOL;
            sclk_h_q     <= CPOL;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            fill_q       <= 2'd0;
            armed_q      <= 1'b0;
            cs_act_h_q   <= 1'b0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            bit_cnt_q    <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            rx_done_q    <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            sclk_s1_q    <= sclk_s1_d;
            sclk_s2_q    <= sclk_s2_d;
            sclk_h_q     <= sclk_h_d;
            cs_s1_q      <= cs_s1_d;
            cs_s2_q      <= cs_s2_d;
            mosi_s1_q    <= mosi_s1_d;
            mosi_s2_q    <= mosi_s2_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            cs_act_h_q   <= cs_act_h_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            rx_done_q    <= rx_done_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            oe_q         <= oe_d;
        end
    end

    assign s_axis.tready = ~hold_valid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = 1'b0;
    assign spi_miso_o    = oe_q & tx_sr_q[DATA_WIDTH-1];
    assign spi_miso_oe_o = oe_q;
    assign tx_underrun_o = underrun_q;
    assign rx_overrun_o  = overrun_q;

endmodule

// File: tb/tb_axis_spi_slave.sv
// Bench for axis_spi_slave: a mode-1 and a mode-0 instance share SCLK/MOSI,
// each with its own chip select, driven by a bit-level SPI master task.
module tb_axis_spi_slave;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn, sclk, mosi, cs1_n, cs0_n;
    logic miso1, oe1, un1_o, ov1_o;
    logic miso0, oe0, un0_o, ov0_o;

    axis_if #(.DATA_WIDTH(W)) s1 ();
    axis_if #(.DATA_WIDTH(W)) m1 ();
    axis_if #(.DATA_WIDTH(W)) s0 ();
    axis_if #(.DATA_WIDTH(W)) m0 ();

    axis_spi_slave #(.SPI_MODE(1), .DATA_WIDTH(W)) u1 (
        .clk_i(clk), .arstn_i(arstn), .spi_clk_i(sclk), .spi_cs_i(cs1_n),
        .spi_mosi_i(mosi), .spi_miso_o(miso1), .spi_miso_oe_o(oe1),
        .s_axis(s1), .m_axis(m1), .tx_underrun_o(un1_o), .rx_overrun_o(ov1_o)
    );

    axis_spi_slave #(.SPI_MODE(0), .DATA_WIDTH(W)) u0 (
        .clk_i(clk), .arstn_i(arstn), .spi_clk_i(sclk), .spi_cs_i(cs0_n),
        .spi_mosi_i(mosi), .spi_miso_o(miso0), .spi_miso_oe_o(oe0),
        .s_axis(s0), .m_axis(m0), .tx_underrun_o(un0_o), .rx_overrun_o(ov0_o)
    );

    int tests_run = 0;
    int failed    = 0;
    int un1_cnt = 0, ov1_cnt = 0, un0_cnt = 0, ov0_cnt = 0;
    logic [W-1:0] got1_q[$];
    logic [W-1:0] got0_q[$];
    logic [W-1:0] exp_q[$];

    // Monitor: record accepted RX words and status pulses, sampled mid-cycle
    always @(negedge clk) begin
        #1;
        if (m1.tvalid === 1'b1 && m1.tready === 1'b1) got1_q.push_back(m1.tdata);
        if (m0.tvalid === 1'b1 && m0.tready === 1'b1) got0_q.push_back(m0.tdata);
        if (un1_o === 1'b1) un1_cnt++;
        if (ov1_o === 1'b1) ov1_cnt++;
        if (un0_o === 1'b1) un0_cnt++;
        if (ov0_o === 1'b1) ov0_cnt++;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got1_q.delete();
        got0_q.delete();
        exp_q.delete();
        un1_cnt = 0; ov1_cnt = 0; un0_cnt = 0; ov0_cnt = 0;
    endtask

    task automatic set_cs(input int dut, input logic v);
        if (dut == 1) cs1_n = v;
        else cs0_n = v;
    endtask

    // Offer one TX word on s_axis, waiting (bounded) for tready.
    task automatic push_tx(input int dut, input logic [W-1:0] d);
        int n;
        n = 0;
        if (dut == 1) begin
            s1.tdata = d; s1.tvalid = 1'b1;
            while (s1.tready !== 1'b1 && n < 300) begin tick(1); n++; end
            tick(1);
            s1.tvalid = 1'b0;
        end else begin
            s0.tdata = d; s0.tvalid = 1'b1;
            while (s0.tready !== 1'b1 && n < 300) begin tick(1); n++; end
            tick(1);
            s0.tvalid = 1'b0;
        end
        tests_run++;
        if (n >= 300) begin
            failed++;
            $display("FAIL push_tx_timeout: dut %0d tready stayed %b, required 1", dut,
                     (dut == 1) ? s1.tready : s0.tready);
        end
    endtask

    // SPI master: nbits MSB first at SCLK = clk/8, returning the MISO bits seen.
    task automatic spi_bits(input int dut, input logic [W-1:0] mo, input int nbits,
                            output logic [W-1:0] mi);
        logic b;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            b = mo[W-1-i];
            if (dut == 0) begin
                mosi = b;
                tick(4);
                mi = {mi[W-2:0], miso0};
                sclk = 1'b1;
                tick(4);
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = b;
                tick(4);
                mi = {mi[W-2:0], miso1};
                sclk = 1'b0;
                tick(4);
            end
        end
    endtask

    task automatic start_cs(input int dut);
        set_cs(dut, 1'b0);
        tick(8);
    endtask

    task automatic end_cs(input int dut);
        tick(4);
        set_cs(dut, 1'b1);
        tick(12);
    endtask

    task automatic apply_reset();
        arstn = 1'b0;
        sclk = 1'b0; mosi = 1'b0; cs1_n = 1'b1; cs0_n = 1'b1;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0; m1.tready = 1'b1;
        s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0; m0.tready = 1'b1;
        tick(3);
        arstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (s1.tready !== 1'b1) begin failed++; $display("FAIL reset_tready: got %b required 1", s1.tready); end
        tests_run++;
        if (m1.tvalid !== 1'b0) begin failed++; $display("FAIL reset_tvalid: got %b required 0", m1.tvalid); end
        tests_run++;
        if (m1.tdata !== 8'h00) begin failed++; $display("FAIL reset_tdata: got %h required 00", m1.tdata); end
        tests_run++;
        if (m1.tlast !== 1'b0) begin failed++; $display("FAIL reset_tlast: got %b required 0", m1.tlast); end
        tests_run++;
        if ({miso1, oe1, un1_o, ov1_o} !== 4'b0000) begin
            failed++; $display("FAIL reset_outputs1: got %b required 0000", {miso1, oe1, un1_o, ov1_o});
        end
        tests_run++;
        if ({miso0, oe0, un0_o, ov0_o, s0.tready, m0.tvalid} !== 6'b000010) begin
            failed++; $display("FAIL reset_outputs0: got %b required 000010",
                               {miso0, oe0, un0_o, ov0_o, s0.tready, m0.tvalid});
        end
        tick(20);
    endtask

    task automatic test_mode1();
        logic [W-1:0] mi;
        clear_obs();
        push_tx(1, 8'h3C);
        start_cs(1);
        spi_bits(1, 8'hA5, 8, mi);
        end_cs(1);
        tests_run++;
        if (mi !== 8'h3C) begin failed++; $display("FAIL mode1_miso: got %h required 3c", mi); end
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'hA5) begin
            failed++; $display("FAIL mode1_rx: got %0d words first %h required 1 word a5",
                               got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
        tests_run++;
        if (un1_cnt != 0 || ov1_cnt != 0) begin
            failed++; $display("FAIL mode1_status: got underrun %0d overrun %0d required 0 0", un1_cnt, ov1_cnt);
        end
    endtask

    task automatic test_mode0();
        logic [W-1:0] mi_a, mi_b;
        clear_obs();
        push_tx(0, 8'h81);
        start_cs(0);
        push_tx(0, 8'h7E);
        spi_bits(0, 8'h12, 8, mi_a);
        spi_bits(0, 8'h34, 8, mi_b);
        end_cs(0);
        tests_run++;
        if (mi_a !== 8'h81) begin failed++; $display("FAIL mode0_miso0: got %h required 81", mi_a); end
        tests_run++;
        if (mi_b !== 8'h7E) begin failed++; $display("FAIL mode0_miso1: got %h required 7e", mi_b); end
        exp_q = '{8'h12, 8'h34};
        tests_run++;
        if (got0_q.size() != exp_q.size()) begin
            failed++; $display("FAIL mode0_rx_count: got %0d required %0d", got0_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (got0_q[i] !== exp_q[i]) begin
                    failed++; $display("FAIL mode0_rx_word%0d: got %h required %h", i, got0_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (ov0_cnt != 0) begin failed++; $display("FAIL mode0_overrun: got %0d required 0", ov0_cnt); end
    endtask

    // Random back-to-back words in one CS, some without TX data queued.
    task automatic test_back_to_back();
        localparam int N = 8;
        logic [W-1:0] tx_w[N], rx_w[N], exp_miso[N], mi;
        bit           present[N];
        int           exp_un;
        clear_obs();
        exp_un = 0;
        for (int i = 0; i < N; i++) begin
            tx_w[i]     = W'($urandom_range(0, 255));
            rx_w[i]     = W'($urandom_range(0, 255));
            present[i]  = ($urandom_range(0, 3) != 0);
            exp_miso[i] = present[i] ? tx_w[i] : '0;
            if (!present[i]) exp_un++;
            exp_q.push_back(rx_w[i]);
        end
        if (present[0]) push_tx(1, tx_w[0]);
        start_cs(1);
        for (int i = 0; i < N; i++) begin
            fork
                begin
                    if (i + 1 < N && present[i+1]) begin
                        tick(8);
                        push_tx(1, tx_w[i+1]);
                    end
                end
                spi_bits(1, rx_w[i], 8, mi);
            join
            tests_run++;
            if (mi !== exp_miso[i]) begin
                failed++; $display("FAIL b2b_miso%0d: got %h required %h", i, mi, exp_miso[i]);
            end
        end
        end_cs(1);
        tests_run++;
        if (got1_q.size() != exp_q.size()) begin
            failed++; $display("FAIL b2b_rx_count: got %0d required %0d", got1_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (got1_q[i] !== exp_q[i]) begin
                    failed++; $display("FAIL b2b_rx_word%0d: got %h required %h", i, got1_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (un1_cnt != exp_un) begin failed++; $display("FAIL b2b_underrun: got %0d required %0d", un1_cnt, exp_un); end
        tests_run++;
        if (ov1_cnt != 0) begin failed++; $display("FAIL b2b_overrun: got %0d required 0", ov1_cnt); end
    endtask

    task automatic test_overrun();
        logic [W-1:0] mi;
        clear_obs();
        m1.tready = 1'b0;
        push_tx(1, 8'hAA);
        start_cs(1);
        fork
            begin tick(8); push_tx(1, 8'h55); end
            spi_bits(1, 8'h11, 8, mi);
        join
        spi_bits(1, 8'h22, 8, mi);
        end_cs(1);
        tests_run++;
        if (m1.tvalid !== 1'b1 || m1.tdata !== 8'h11) begin
            failed++; $display("FAIL overrun_hold: got valid %b data %h required 1 11", m1.tvalid, m1.tdata);
        end
        tests_run++;
        if (ov1_cnt != 1) begin failed++; $display("FAIL overrun_pulse: got %0d required 1", ov1_cnt); end
        m1.tready = 1'b1;
        tick(3);
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'h11) begin
            failed++; $display("FAIL overrun_drain: got %0d words first %h required 1 word 11",
                               got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
        tests_run++;
        if (m1.tvalid !== 1'b0) begin failed++; $display("FAIL overrun_tvalid_clear: got %b required 0", m1.tvalid); end
    endtask

    task automatic test_cs_abort();
        logic [W-1:0] mi_p, mi;
        clear_obs();
        push_tx(1, 8'h96);
        start_cs(1);
        spi_bits(1, 8'hB0, 5, mi_p);
        end_cs(1);
        push_tx(1, 8'h69);
        start_cs(1);
        spi_bits(1, 8'hC3, 8, mi);
        end_cs(1);
        tests_run++;
        if (mi_p !== 8'h12) begin failed++; $display("FAIL abort_partial_miso: got %h required 12", mi_p); end
        tests_run++;
        if (mi !== 8'h69) begin failed++; $display("FAIL abort_next_miso: got %h required 69", mi); end
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'hC3) begin
            failed++; $display("FAIL abort_rx: got %0d words first %h required 1 word c3",
                               got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
        tests_run++;
        if (un1_cnt != 0 || ov1_cnt != 0) begin
            failed++; $display("FAIL abort_status: got underrun %0d overrun %0d required 0 0", un1_cnt, ov1_cnt);
        end
    endtask

    task automatic test_underrun();
        logic [W-1:0] mi;
        clear_obs();
        start_cs(1);
        spi_bits(1, 8'h5E, 8, mi);
        end_cs(1);
        tests_run++;
        if (mi !== 8'h00) begin failed++; $display("FAIL underrun_miso: got %h required 00", mi); end
        tests_run++;
        if (un1_cnt != 1) begin failed++; $display("FAIL underrun_pulse: got %0d required 1", un1_cnt); end
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'h5E) begin
            failed++; $display("FAIL underrun_rx: got %0d words first %h required 1 word 5e",
                               got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] mi, mi_rest;
        clear_obs();
        push_tx(1, 8'hF0);
        start_cs(1);
        spi_bits(1, 8'hE7, 3, mi);
        arstn = 1'b0;
        tick(1);
        arstn = 1'b1;
        spi_bits(1, 8'hFF, 5, mi_rest);
        tests_run++;
        if (mi_rest !== 8'h00 || oe1 !== 1'b0) begin
            failed++; $display("FAIL rstmid_idle: got miso %h oe %b required 00 0", mi_rest, oe1);
        end
        end_cs(1);
        push_tx(1, 8'hC6);
        start_cs(1);
        spi_bits(1, 8'h5A, 8, mi);
        end_cs(1);
        tests_run++;
        if (mi !== 8'hC6) begin failed++; $display("FAIL rstmid_miso: got %h required c6", mi); end
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'h5A) begin
            failed++; $display("FAIL rstmid_rx: got %0d words first %h required 1 word 5a",
                               got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
        tests_run++;
        if (un1_cnt != 0 || ov1_cnt != 0) begin
            failed++; $display("FAIL rstmid_status: got underrun %0d overrun %0d required 0 0", un1_cnt, ov1_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode0();
        test_back_to_back();
        test_overrun();
        test_cs_abort();
        test_underrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
